channel_ctrl: RTL

Synchronous digital controller that drives one analog channel's control pins and consumes its outputs. It arms the channel, detects a discriminator hit, and sequences ADC sample and conversion. It captures the ADC word with a timestamp, queues the event for the digital core's readout, and resets the CSA before re-arming. It sits between the analog channel and the chip-level event router, one instance per pixel.

---
 rtl/channel_ctrl_pkg.sv | 27 ++
 rtl/event_fifo.sv | 61 ++++++
 rtl/channel_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/channel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// channel_ctrl_pkg
// Shared types and helpers for the pixel channel controller.
//   state_t      : controller FSM states
//   EVENT_W      : event word width ({timestamp, adc}) for the default sizes
//   clamp_count(): maps a programmed count of 0 to 1
// -----------------------------------------------------------------------------
package channel_ctrl_pkg;

  localparam int ADCBITS_DEF = 10;
  localparam int TS_BITS_DEF = 24;
  localparam int EVENT_W     = TS_BITS_DEF + ADCBITS_DEF;

  typedef enum logic [2:0] {
    RESET_CSA,
    ARMED,
    SAMPLE,
    CONVERT,
    STORE
  } state_t;

  // A programmed duration of zero still has to occupy one cycle.
  function automatic int unsigned clamp_count(input int unsigned count);
    return (count == 0) ? 32'd1 : count;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous FIFO holding captured channel events until readout.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the queue)
//   i_push/i_data: write request and word
//   i_pop        : read request (ignored when empty)
//   o_data       : head entry, forced to 0 while empty
//   o_full/o_empty: occupancy flags
// A push while full succeeds only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module event_fifo
  import channel_ctrl_pkg::*;
#(
  parameter int WIDTH = EVENT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define valid contents and
  // the head output is masked while empty, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/channel_ctrl.sv
// -----------------------------------------------------------------------------
// channel_ctrl
// Per-pixel controller for one analog channel: arms the channel, detects a
// discriminator hit, sequences CSA sample and ADC conversion, captures
// {timestamp, adc} into an event queue, then resets the CSA and re-arms.
// Ports:
//   clk, reset_n          : core clock, asynchronous active-low reset
//   hit, done, dout       : analog channel outputs (hit/done asynchronous)
//   sample, strobe, csa_reset : analog channel controls
//   enable                : channel enable (checked only when arming an event)
//   reset_cycles, sample_cycles, timeout_cycles : durations, 0 behaves as 1
//   timestamp             : free-running time counter
//   event_valid/ready/data: readout handshake, data = {timestamp, adc}
//   overflow, timeout_err : sticky error flags, cleared only by reset_n
// -----------------------------------------------------------------------------
module channel_ctrl
  import channel_ctrl_pkg::*;
#(
  parameter int ADCBITS    = 10,
  parameter int TS_BITS    = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       hit,
  input  logic                       done,
  input  logic [ADCBITS-1:0]         dout,
  output logic                       sample,
  output logic                       strobe,
  output logic                       csa_reset,
  input  logic                       enable,
  input  logic [CNT_BITS-1:0]        reset_cycles,
  input  logic [CNT_BITS-1:0]        sample_cycles,
  input  logic [CNT_BITS-1:0]        timeout_cycles,
  input  logic [TS_BITS-1:0]         timestamp,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic [TS_BITS+ADCBITS-1:0] event_data,
  output logic                       overflow,
  output logic                       timeout_err
);

  localparam int EW = TS_BITS + ADCBITS;

  // ---------------------------------------------------------------------------
  // Synchronizers: two flops each; r_hit_d keeps the previous synchronized hit
  // so a rising edge is consumed whatever state the FSM is in.
  // ---------------------------------------------------------------------------
  logic r_hit_s1, r_hit_s2, r_hit_d;
  logic r_done_s1, r_done_s2;
  logic w_hit_rise;
  logic w_done_sync;

  // NOTE: every flop uses <= so all registers see pre-edge values; a blocking
  // assignment here would collapse the synchronizer chain into one stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_s1  <= 1'b0;
      r_hit_s2  <= 1'b0;
      r_hit_d   <= 1'b0;
      r_done_s1 <= 1'b0;
      r_done_s2 <= 1'b0;
    end else begin
      r_hit_s1  <= hit;
      r_hit_s2  <= r_hit_s1;
      r_hit_d   <= r_hit_s2;
      r_done_s1 <= done;
      r_done_s2 <= r_done_s1;
    end
  end

  assign w_hit_rise  = r_hit_s2 && !r_hit_d;
  assign w_done_sync = r_done_s2;

  // ---------------------------------------------------------------------------
  // FSM with a shared up-counter: it restarts at 0 on every state change, and
  // a state of length N ends when the counter shows N-1.
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic                w_reset_last;
  logic                w_sample_last;
  logic                w_conv_last;
  logic                w_capture_ts;
  logic                w_latch_adc;
  logic                w_timeout;
  logic                w_push;

  assign w_reset_last  = (32'(r_cnt) + 32'd1) >= clamp_count(32'(reset_cycles));
  assign w_sample_last = (32'(r_cnt) + 32'd1) >= clamp_count(32'(sample_cycles));
  assign w_conv_last   = (32'(r_cnt) + 32'd1) >= clamp_count(32'(timeout_cycles));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture_ts = 1'b0;
    w_latch_adc  = 1'b0;
    w_timeout    = 1'b0;
    w_push       = 1'b0;
    sample       = 1'b0;
    strobe       = 1'b0;
    csa_reset    = 1'b0;
    case (r_state)
      RESET_CSA: begin
        csa_reset = 1'b1;
        if (w_reset_last) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (w_hit_rise && enable) begin
          w_state_nxt  = SAMPLE;
          w_capture_ts = 1'b1;
        end
      end
      SAMPLE: begin
        sample = 1'b1;
        if (w_sample_last) w_state_nxt = CONVERT;
      end
      CONVERT: begin
        strobe = 1'b1;
        // A conversion finishing in the last allowed cycle still counts.
        if (w_done_sync) begin
          w_state_nxt = STORE;
          w_latch_adc = 1'b1;
        end else if (w_conv_last) begin
          w_state_nxt = RESET_CSA;
          w_timeout   = 1'b1;
        end
      end
      STORE: begin
        w_push      = 1'b1;
        w_state_nxt = RESET_CSA;
      end
      default: w_state_nxt = RESET_CSA;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RESET_CSA;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != ARMED)  r_cnt <= r_cnt + CNT_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Event capture, sticky flags and queue
  // ---------------------------------------------------------------------------
  logic [TS_BITS-1:0] r_ts;
  logic [ADCBITS-1:0] r_adc;
  logic               r_overflow;
  logic               r_timeout_err;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;

  assign w_pop  = event_valid && event_ready;
  // A pop in the same cycle frees the slot, so only an unrelieved full drops.
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts          <= '0;
      r_adc         <= '0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_capture_ts) r_ts  <= timestamp;
      if (w_latch_adc)  r_adc <= dout;
      if (w_drop)       r_overflow    <= 1'b1;
      if (w_timeout)    r_timeout_err <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  ({r_ts, r_adc}),
    .i_pop   (w_pop),
    .o_data  (event_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign event_valid = !w_empty;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule
